// File: rtl/load_cache.sv
// rtl/load_cache.sv - direct-mapped one-word-line load cache with blocking miss handling
module load_cache #(
    parameter int WORD_SIZE  = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_read_enable,
    input  logic [WORD_SIZE-1:0] c_ptr,
    output logic [WORD_SIZE-1:0] c_out,
    output logic                 c_hit,
    output logic                 c_done,
    output logic                 c_busy,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_valid,
    input  logic                 inv_valid,
    input  logic [WORD_SIZE-1:0] inv_addr,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = WORD_SIZE - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESPOND} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORD_SIZE-1:0]   data_q [LINES];
    logic [WORD_SIZE-1:0]   addr_q;
    logic                   kill_q;
    logic                   c_done_q, c_hit_q;
    logic [WORD_SIZE-1:0]   c_out_q;
    logic [CNT_WIDTH-1:0]   hit_count_q, miss_count_q;

    logic [INDEX_BITS-1:0]  c_idx, inv_idx, lat_idx;
    logic [TAG_W-1:0]       c_tag, inv_tag;
    logic                   accept, lookup_hit, inv_hits_line, inv_kills_fill, fill, allocate;

    assign c_idx   = c_ptr[INDEX_BITS-1:0];
    assign c_tag   = c_ptr[WORD_SIZE-1:INDEX_BITS];
    assign inv_idx = inv_addr[INDEX_BITS-1:0];
    assign inv_tag = inv_addr[WORD_SIZE-1:INDEX_BITS];
    assign lat_idx = addr_q[INDEX_BITS-1:0];

    assign accept         = (state_q == IDLE) && c_read_enable;
    // A same-cycle invalidate of the looked-up address wins over the lookup.
    assign lookup_hit     = valid_q[c_idx] && (tag_q[c_idx] == c_tag) &&
                            !(inv_valid && (inv_addr == c_ptr));
    assign inv_hits_line  = inv_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
    assign inv_kills_fill = inv_valid && (inv_addr == addr_q);
    assign fill           = (state_q == MISS_WAIT) && mem_valid;
    assign allocate       = fill && !kill_q && !inv_kills_fill;

    always_comb begin
        state_d = state_q;
        c_busy  = (state_q != IDLE);
        mem_req = (state_q == MISS_REQ);
        case (state_q)
            IDLE:      if (accept && !lookup_hit) state_d = MISS_REQ;
            MISS_REQ:  state_d = MISS_WAIT;
            MISS_WAIT: if (mem_valid) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            c_done_q     <= 1'b0;
            c_hit_q      <= 1'b0;
            c_out_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q  <= state_d;
            c_done_q <= 1'b0;
            if (accept) begin
                addr_q <= c_ptr;
                kill_q <= 1'b0;
                if (lookup_hit) begin
                    c_done_q <= 1'b1;
                    c_hit_q  <= 1'b1;
                    c_out_q  <= data_q[c_idx];
                    if (hit_count_q != '1) hit_count_q <= hit_count_q + CNT_WIDTH'(1);
                end else if (miss_count_q != '1) begin
                    miss_count_q <= miss_count_q + CNT_WIDTH'(1);
                end
            end
            // Remember an invalidate of the outstanding miss so the fill is not allocated.
            if ((state_q == MISS_REQ || state_q == MISS_WAIT) && inv_kills_fill) kill_q <= 1'b1;
            if (inv_hits_line) valid_q[inv_idx] <= 1'b0;
            if (fill) begin
                c_done_q <= 1'b1;
                c_hit_q  <= 1'b0;
                c_out_q  <= mem_data;
            end
            if (allocate) valid_q[lat_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && allocate) begin
            tag_q[lat_idx]  <= addr_q[WORD_SIZE-1:INDEX_BITS];
            data_q[lat_idx] <= mem_data;
        end
    end

    assign c_out      = c_out_q;
    assign c_hit      = c_hit_q;
    assign c_done     = c_done_q;
    assign mem_addr   = addr_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_load_cache.sv
// tb/tb_load_cache.sv - directed self-checking bench for load_cache
module tb_load_cache;
    localparam int WS = 32;
    localparam int IB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, c_read_enable, mem_valid, inv_valid;
    logic [WS-1:0] c_ptr, mem_data, inv_addr;
    logic [WS-1:0] c_out, mem_addr;
    logic          c_hit, c_done, c_busy, mem_req;
    logic [CW-1:0] hit_count, miss_count;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int req_cnt = 0;

    load_cache #(.WORD_SIZE(WS), .INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .c_read_enable(c_read_enable), .c_ptr(c_ptr),
        .c_out(c_out), .c_hit(c_hit), .c_done(c_done), .c_busy(c_busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (c_done) done_cnt++;
        if (mem_req) req_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic read_miss(input logic [31:0] a, input logic [31:0] d,
                             input bit inv_acc, input bit inv_wait);
        int dn;
        c_read_enable = 1'b1;
        c_ptr = a;
        if (inv_acc) begin
            inv_valid = 1'b1;
            inv_addr = a;
        end
        cyc();
        c_read_enable = 1'b0;
        inv_valid = 1'b0;
        c_ptr = '0;
        dn = done_cnt;
        chk("miss_req", mem_req, 1);
        chk("miss_addr", mem_addr, a);
        chk("miss_busy", c_busy, 1);
        cyc();
        if (inv_wait) begin
            inv_valid = 1'b1;
            inv_addr = a;
        end
        cyc();
        inv_valid = 1'b0;
        cyc();
        mem_valid = 1'b1;
        mem_data = d;
        cyc();
        mem_valid = 1'b0;
        chk("fill_done", c_done, 1);
        chk("fill_hit", c_hit, 0);
        chk("fill_out", c_out, d);
        chk("fill_busy", c_busy, 1);
        cyc();
        chk("fill_done_once", done_cnt - dn, 1);
        chk("fill_idle", c_busy, 0);
    endtask

    task automatic read_hit(input logic [31:0] a, input logic [31:0] d);
        int rq;
        rq = req_cnt;
        c_read_enable = 1'b1;
        c_ptr = a;
        cyc();
        c_read_enable = 1'b0;
        chk("hit_done", c_done, 1);
        chk("hit_hit", c_hit, 1);
        chk("hit_out", c_out, d);
        chk("hit_busy", c_busy, 0);
        chk("hit_noreq", req_cnt - rq, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int rq, dn;
        reset = 1'b1;
        c_read_enable = 1'b0;
        c_ptr = '0;
        mem_valid = 1'b0;
        mem_data = '0;
        inv_valid = 1'b0;
        inv_addr = '0;
        repeat (2) cyc();
        chk("rst_done", c_done, 0);
        chk("rst_hit", c_hit, 0);
        chk("rst_busy", c_busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_out", c_out, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        reset = 1'b0;
        cyc();

        // cold miss then hit
        read_miss(32'h25, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("cold_misses", miss_count, 1);
        read_hit(32'h25, 32'hDEADBEEF);
        chk("hit_hits", hit_count, 1);
        cyc();
        chk("hold_done", c_done, 0);
        chk("hold_out", c_out, 32'hDEADBEEF);
        chk("hold_hit", c_hit, 1);

        // conflict on index 5
        read_miss(32'h35, 32'h12345678, 1'b0, 1'b0);
        read_miss(32'h25, 32'hDEADBEEF, 1'b0, 1'b0);
        read_hit(32'h25, 32'hDEADBEEF);
        chk("conf_misses", miss_count, 3);
        chk("conf_hits", hit_count, 2);

        // invalidate same cycle as lookup, then during the wait
        read_miss(32'h25, 32'hDEADBEEF, 1'b1, 1'b1);
        read_miss(32'h25, 32'hCAFEF00D, 1'b0, 1'b0);
        read_hit(32'h25, 32'hCAFEF00D);
        chk("inv_misses", miss_count, 5);
        chk("inv_hits", hit_count, 3);

        // fill 8 lines, then stream 8 back-to-back hits
        for (int i = 0; i < 8; i++) read_miss(32'h40 + i, 32'hA000_0000 + i * 32'h111, 1'b0, 1'b0);
        rq = req_cnt;
        c_read_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_ptr = 32'h40 + i;
            cyc();
            chk("b2b_done", c_done, 1);
            chk("b2b_out", c_out, 32'hA000_0000 + i * 32'h111);
            chk("b2b_busy", c_busy, 0);
        end
        c_read_enable = 1'b0;
        cyc();
        chk("b2b_noreq", req_cnt - rq, 0);
        chk("b2b_hits", hit_count, 11);
        chk("b2b_misses", miss_count, 13);

        // hit counter saturates at 15
        for (int i = 0; i < 6; i++) read_hit(32'h40, 32'hA000_0000);
        chk("sat_hits", hit_count, 15);

        // reset in MISS_WAIT, late mem_valid ignored
        c_read_enable = 1'b1;
        c_ptr = 32'h77;
        cyc();
        c_read_enable = 1'b0;
        cyc();
        chk("mid_busy", c_busy, 1);
        reset = 1'b1;
        dn = done_cnt;
        cyc();
        reset = 1'b0;
        chk("mid_idle", c_busy, 0);
        chk("mid_hits", hit_count, 0);
        chk("mid_misses", miss_count, 0);
        chk("mid_addr", mem_addr, 0);
        cyc();
        mem_valid = 1'b1;
        mem_data = 32'hBAD0BAD0;
        cyc();
        mem_valid = 1'b0;
        cyc();
        chk("mid_nodone", done_cnt - dn, 0);
        chk("mid_out", c_out, 0);
        read_miss(32'h40, 32'h55, 1'b0, 1'b0);
        chk("mid_coldmiss", miss_count, 1);
        chk("mid_nohit", hit_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_cache.md
LOAD_CACHE -- requirements
Module: load_cache

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data and address width in bits; addresses are word addresses.
REQ-002 SHALL have parameter INDEX_BITS, default 4: 2^INDEX_BITS direct-mapped one-word lines.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 c_read_enable  input  1  load reservation station requests a read.
REQ-007 c_ptr  input  WORD_SIZE  read word address, sampled when the request is accepted.
REQ-008 c_out  output  WORD_SIZE  read data, valid while c_done=1.
REQ-009 c_hit  output  1  1 = served from a line, 0 = served after a fill; valid while c_done=1.
REQ-010 c_done  output  1  one-cycle response strobe.
REQ-011 c_busy  output  1  request held or in progress; new requests not accepted.
REQ-012 mem_req  output  1  one-cycle fill request to backing memory.
REQ-013 mem_addr  output  WORD_SIZE  fill address, held from the mem_req cycle until mem_valid.
REQ-014 mem_data  input  WORD_SIZE  fill data.
REQ-015 mem_valid  input  1  fill data strobe; one cycle, at least 1 cycle after mem_req.
REQ-016 inv_valid  input  1  store-path invalidate strobe.
REQ-017 inv_addr  input  WORD_SIZE  word address to invalidate.
REQ-018 hit_count, miss_count  output  CNT_WIDTH each  saturating statistics counters.

Function
REQ-019 SHALL be direct-mapped: index = c_ptr[INDEX_BITS-1:0]; tag = c_ptr[WORD_SIZE-1:INDEX_BITS]; each line holds valid, tag, data.
REQ-020 States SHALL be IDLE, MISS_REQ, MISS_WAIT, RESPOND.
REQ-021 In IDLE with c_read_enable=1 the block SHALL latch c_ptr and do a tag compare in that cycle.
- Hit: next cycle c_done=1, c_hit=1, c_out=line data, hit_count+1; stay in IDLE (latency 1).
- Miss: go to MISS_REQ; miss_count+1.
REQ-022 MISS_REQ SHALL last one cycle with mem_req=1 and mem_addr=latched address, then go to MISS_WAIT.
REQ-023 In MISS_WAIT the block SHALL wait indefinitely for mem_valid; on mem_valid it SHALL write data and tag, set the line valid, and go to RESPOND.
REQ-024 RESPOND SHALL last one cycle with c_done=1, c_hit=0 and c_out=fill data, then return to IDLE.
REQ-025 c_busy SHALL be 1 in MISS_REQ, MISS_WAIT and RESPOND; c_read_enable is ignored while c_busy=1.
REQ-026 A request can be accepted in the same IDLE cycle that c_done of a hit is asserted, which gives back-to-back hits at one per cycle.
REQ-027 c_out and c_hit SHALL hold their last values when c_done=0.
REQ-028 inv_valid in any state SHALL clear the valid bit of line inv_addr[INDEX_BITS-1:0] if that line's tag matches.
REQ-029 inv_valid and a lookup to the same address in the same IDLE cycle SHALL give a miss, because the invalidate takes priority.
REQ-030 If inv_valid matches the latched miss address during MISS_REQ or MISS_WAIT, or in the cycle mem_valid arrives, the fill data SHALL still be returned but the line SHALL NOT be allocated.
REQ-031 mem_valid outside MISS_WAIT SHALL be ignored.
REQ-032 Counters SHALL saturate at 2^CNT_WIDTH-1 and not wrap.

Reset
REQ-033 Reset SHALL:
- clear every line valid bit;
- force IDLE;
- drive c_done, c_hit, c_busy and mem_req to 0;
- drive c_out, mem_addr, hit_count and miss_count to 0.
REQ-034 Reset during MISS_REQ or MISS_WAIT SHALL abandon the miss with no c_done; a later mem_valid SHALL be ignored per REQ-031.
REQ-035 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 Cold miss: reset, read 0x00000025, mem_valid 3 cycles after mem_req with data 0xDEADBEEF -> mem_addr=0x25; one c_done, c_hit=0, c_out=0xDEADBEEF; miss_count=1.
REQ-037 Hit: repeat the read of 0x25 -> c_done the next cycle, c_hit=1, c_out=0xDEADBEEF, no mem_req; hit_count=1.
REQ-038 Conflict: read 0x35 (same index 5), fill 0x12345678, then read 0x25 -> both reads miss; line 5 ends with tag for 0x25.
REQ-039 Invalidate: after filling 0x25, pulse inv_valid with 0x25 in the same cycle as a read of 0x25 -> miss, mem_req issued; then an invalidate during MISS_WAIT -> data returned and the next read of 0x25 misses again.
REQ-040 Reset mid-miss: reset in MISS_WAIT, then mem_valid 2 cycles later -> no c_done, state IDLE, all lines invalid, counters 0.
REQ-041 Back-to-back: 8 consecutive hit reads to distinct cached lines -> 8 consecutive c_done cycles with correct data, c_busy stays 0.
